car_sprite_scheduler: RTL and testbench

CAR_SPRITE_SCHEDULER -- requirements
Module: car_sprite_scheduler

---
 rtl/car_sprite_scheduler.sv | 216 +++++++++++++++++++++
 tb/tb_car_sprite_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/car_sprite_scheduler.sv
// car_sprite_scheduler
// Shares one bitmap ROM between NUM_CARS sprite slots. During horizontal
// blanking a small FSM fetches one bitmap row per visible slot for the next
// scan line into shadow entries, then commits them to the active entries in a
// single cycle. The pixel path reads only the active entries, picks the
// lowest-index opaque slot and registers rgb/on, with 1 cycle of latency.
//
// Ports
//   pclk, reset         pixel clock, synchronous active-high reset
//   pixel_x, pixel_y    current scan position
//   hblank_start        one-cycle pulse that starts a fetch
//   car_x/y/owner/enable  packed per-slot sprite descriptors (slot i at 8i/10i/3i/i)
//   rom_en, rom_addr    bitmap ROM read port (address = owner*32 + row)
//   rom_data            ROM line, valid one cycle after rom_en
//   rgb, on             registered sprite colour / opaque-pixel flag
//   busy                fetch in progress
//   overrun             sticky: hblank_start arrived while busy
module car_sprite_scheduler #(
    parameter int NUM_CARS   = 4,
    parameter int CAR_WIDTH  = 16,
    parameter int CAR_HEIGHT = 32,
    parameter int LAST_LINE  = 524
) (
    input  logic                    pclk,
    input  logic                    reset,
    input  logic [9:0]              pixel_x,
    input  logic [9:0]              pixel_y,
    input  logic                    hblank_start,
    input  logic [8*NUM_CARS-1:0]   car_x,
    input  logic [10*NUM_CARS-1:0]  car_y,
    input  logic [3*NUM_CARS-1:0]   car_owner,
    input  logic [NUM_CARS-1:0]     car_enable,
    output logic                    rom_en,
    output logic [7:0]              rom_addr,
    input  logic [3*CAR_WIDTH-1:0]  rom_data,
    output logic [2:0]              rgb,
    output logic                    on,
    output logic                    busy,
    output logic                    overrun
);

    localparam int IDX_W = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CARS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_WAIT, S_STORE, S_NEXT, S_COMMIT
    } state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       idx_q;
    logic [9:0]             target_y_q;
    logic                   rom_en_q;
    logic [7:0]             rom_addr_q;
    logic                   overrun_q;
    logic [2:0]             rgb_q;
    logic                   on_q;

    logic                   shadow_valid_q [NUM_CARS];
    logic [7:0]             shadow_x_q     [NUM_CARS];
    logic [3*CAR_WIDTH-1:0] shadow_line_q  [NUM_CARS];
    logic                   active_valid_q [NUM_CARS];
    logic [7:0]             active_x_q     [NUM_CARS];
    logic [3*CAR_WIDTH-1:0] active_line_q  [NUM_CARS];

    logic [7:0]             car_x_arr     [NUM_CARS];
    logic [9:0]             car_y_arr     [NUM_CARS];
    logic [2:0]             car_owner_arr [NUM_CARS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CARS; gi++) begin : g_unpack
            assign car_x_arr[gi]     = car_x[8*gi +: 8];
            assign car_y_arr[gi]     = car_y[10*gi +: 10];
            assign car_owner_arr[gi] = car_owner[3*gi +: 3];
        end
    endgenerate

    // Slot evaluation. CHECK evaluates slot idx_q; NEXT advances and evaluates
    // the following slot in the same cycle, so a visible slot costs exactly
    // three cycles (evaluate, WAIT, STORE) and the worst case is 3*NUM_CARS+2.
    logic [IDX_W-1:0] eval_idx;
    logic [9:0]       eval_row;
    logic             eval_visible;
    logic [9:0]       next_target_y;

    always_comb begin
        eval_idx      = (state_q == S_CHECK) ? idx_q : idx_q + 1'b1;
        eval_row      = target_y_q - car_y_arr[eval_idx];
        eval_visible  = car_enable[eval_idx]
                        && (target_y_q >= car_y_arr[eval_idx])
                        && (eval_row < 10'(CAR_HEIGHT));
        next_target_y = (pixel_y == 10'(LAST_LINE)) ? 10'd0 : pixel_y + 10'd1;
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            target_y_q <= '0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            overrun_q  <= 1'b0;
            for (int i = 0; i < NUM_CARS; i++) begin
                shadow_valid_q[i] <= 1'b0;
                active_valid_q[i] <= 1'b0;
            end
        end else begin
            rom_en_q <= 1'b0;
            if (state_q != S_IDLE && hblank_start) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (hblank_start) begin
                        target_y_q <= next_target_y;
                        idx_q      <= '0;
                        state_q    <= S_CHECK;
                    end
                end
                S_CHECK, S_NEXT: begin
                    if (state_q == S_NEXT && idx_q == LAST_IDX) begin
                        state_q <= S_COMMIT;
                    end else begin
                        idx_q <= eval_idx;
                        if (eval_visible) begin
                            // rom_en is high during WAIT; data arrives in STORE.
                            rom_en_q   <= 1'b1;
                            rom_addr_q <= {car_owner_arr[eval_idx], eval_row[4:0]};
                            state_q    <= S_WAIT;
                        end else begin
                            shadow_valid_q[eval_idx] <= 1'b0;
                            state_q                  <= S_NEXT;
                        end
                    end
                end
                S_WAIT: begin
                    state_q <= S_STORE;
                end
                S_STORE: begin
                    shadow_line_q[idx_q]  <= rom_data;
                    shadow_x_q[idx_q]     <= car_x_arr[idx_q];
                    shadow_valid_q[idx_q] <= 1'b1;
                    state_q               <= S_NEXT;
                end
                S_COMMIT: begin
                    for (int i = 0; i < NUM_CARS; i++) begin
                        active_valid_q[i] <= shadow_valid_q[i];
                        active_x_q[i]     <= shadow_x_q[i];
                        active_line_q[i]  <= shadow_line_q[i];
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Per-slot hit detection on the active entries only.
    logic [NUM_CARS-1:0]   slot_hit;
    logic [3*NUM_CARS-1:0] slot_col;

    generate
        for (gi = 0; gi < NUM_CARS; gi++) begin : g_slot
            logic [8:0] lx;
            logic [2:0] col;
            logic       in_win;
            // Bit 8 of the 9-bit difference is the borrow: pixel left of the sprite.
            assign lx     = {1'b0, pixel_x[7:0]} - {1'b0, active_x_q[gi]};
            assign in_win = active_valid_q[gi] && (pixel_x[9:8] == 2'b01)
                            && !lx[8] && (lx < 9'(CAR_WIDTH));
            always_comb begin
                col = 3'b000;
                for (int c = 0; c < CAR_WIDTH; c++) begin
                    if (lx == 9'(c)) begin
                        col = active_line_q[gi][3*c +: 3];
                    end
                end
            end
            assign slot_hit[gi]         = in_win && (col != 3'b000);
            assign slot_col[3*gi +: 3]  = col;
        end
    endgenerate

    logic [2:0] rgb_d;
    logic       on_d;

    // Walk from the highest index down so the lowest hitting slot wins.
    always_comb begin
        rgb_d = 3'b000;
        on_d  = 1'b0;
        for (int i = NUM_CARS - 1; i >= 0; i--) begin
            if (slot_hit[i]) begin
                rgb_d = slot_col[3*i +: 3];
                on_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            rgb_q <= 3'b000;
            on_q  <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            on_q  <= on_d;
        end
    end

    assign rom_en   = rom_en_q;
    assign rom_addr = rom_addr_q;
    assign rgb      = rgb_q;
    assign on       = on_q;
    assign busy     = (state_q != S_IDLE);
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_car_sprite_scheduler.sv
module tb_car_sprite_scheduler;

    localparam int N          = 4;
    localparam int CAR_WIDTH  = 16;
    localparam int CAR_HEIGHT = 32;
    localparam int LAST_LINE  = 524;

    logic                   pclk = 1'b0;
    logic                   reset;
    logic [9:0]             pixel_x;
    logic [9:0]             pixel_y;
    logic                   hblank_start;
    logic [8*N-1:0]         car_x;
    logic [10*N-1:0]        car_y;
    logic [3*N-1:0]         car_owner;
    logic [N-1:0]           car_enable;
    logic                   rom_en;
    logic [7:0]             rom_addr;
    logic [3*CAR_WIDTH-1:0] rom_data;
    logic [2:0]             rgb;
    logic                   on;
    logic                   busy;
    logic                   overrun;

    car_sprite_scheduler #(
        .NUM_CARS(N), .CAR_WIDTH(CAR_WIDTH), .CAR_HEIGHT(CAR_HEIGHT), .LAST_LINE(LAST_LINE)
    ) dut (
        .pclk(pclk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .hblank_start(hblank_start), .car_x(car_x), .car_y(car_y),
        .car_owner(car_owner), .car_enable(car_enable), .rom_en(rom_en),
        .rom_addr(rom_addr), .rom_data(rom_data), .rgb(rgb), .on(on),
        .busy(busy), .overrun(overrun)
    );

    always #5 pclk = ~pclk;

    // Slot descriptors as plain arrays, packed onto the DUT ports.
    logic [7:0] cx [N];
    logic [9:0] cy [N];
    logic [2:0] co [N];
    logic       ce [N];

    always_comb begin
        car_x = '0; car_y = '0; car_owner = '0; car_enable = '0;
        for (int i = 0; i < N; i++) begin
            car_x[8*i +: 8]      = cx[i];
            car_y[10*i +: 10]    = cy[i];
            car_owner[3*i +: 3]  = co[i];
            car_enable[i]        = ce[i];
        end
    end

    // Synchronous ROM: data appears one cycle after the strobe.
    logic [3*CAR_WIDTH-1:0] rom_mem [256];
    always @(posedge pclk) begin
        if (rom_en) rom_data <= rom_mem[rom_addr];
    end

    // Reference model state: what each slot should display on the next line.
    bit                     exp_valid [N];
    int                     exp_x     [N];
    logic [3*CAR_WIDTH-1:0] exp_line  [N];
    int                     exp_addrs [$];
    int                     got_addrs [$];
    int                     busy_cnt;
    int                     checks = 0;
    int                     errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Which slots are visible on the line after py, and what they fetch.
    task automatic model_fetch(input int py);
        int ty, row, a;
        ty = (py == LAST_LINE) ? 0 : py + 1;
        exp_addrs.delete();
        for (int i = 0; i < N; i++) begin
            row = ty - int'(cy[i]);
            if (ce[i] && row >= 0 && row < CAR_HEIGHT) begin
                a = int'(co[i]) * 32 + row;
                exp_addrs.push_back(a);
                exp_valid[i] = 1'b1;
                exp_x[i]     = int'(cx[i]);
                exp_line[i]  = rom_mem[a];
            end else begin
                exp_valid[i] = 1'b0;
            end
        end
    endtask

    // Expected {on, rgb} for a pixel column.
    function automatic logic [3:0] model_pix(input int px);
        int lx;
        logic [2:0] col;
        for (int i = 0; i < N; i++) begin
            if (exp_valid[i] && (px / 256) == 1) begin
                lx = (px % 256) - exp_x[i];
                if (lx >= 0 && lx < CAR_WIDTH) begin
                    col = 3'((exp_line[i] >> (3 * lx)) & 48'h7);
                    if (col != 3'b000) return {1'b1, col};
                end
            end
        end
        return 4'b0000;
    endfunction

    // Pulse hblank at line py; optionally a second pulse on busy cycle 5.
    task automatic fetch(input int py, input bit second, input int py2);
        int cyc;
        model_fetch(py);
        got_addrs.delete();
        busy_cnt = 0;
        pixel_y = 10'(py);
        @(negedge pclk); hblank_start = 1'b1;
        @(negedge pclk); hblank_start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 60) begin
            busy_cnt++;
            if (rom_en === 1'b1) got_addrs.push_back(int'(rom_addr));
            if (second && busy_cnt == 5) begin
                pixel_y = 10'(py2);
                hblank_start = 1'b1;
            end else begin
                hblank_start = 1'b0;
            end
            @(negedge pclk);
            cyc++;
        end
        hblank_start = 1'b0;
        pixel_y = 10'(py);
        chk("fetch_done", 64'(cyc < 60), 64'd1);
        chk("busy_max", 64'(busy_cnt <= 3 * N + 2), 64'd1);
        chk("addr_count", 64'(got_addrs.size()), 64'(exp_addrs.size()));
        for (int k = 0; k < got_addrs.size() && k < exp_addrs.size(); k++)
            chk($sformatf("rom_addr[%0d]", k), 64'(got_addrs[k]), 64'(exp_addrs[k]));
        $display("fetch py=%0d rom_reads=%0d busy_cycles=%0d overrun=%0b", py, got_addrs.size(), busy_cnt, overrun);
    endtask

    // Drive pixel_x lo..hi on negedges; each output is checked one cycle later.
    task automatic scan(input int lo, input int hi);
        int bad;
        bad = errors;
        @(negedge pclk); pixel_x = 10'(lo);
        for (int px = lo + 1; px <= hi + 1; px++) begin
            @(negedge pclk);
            chk($sformatf("pix x=%0d", px - 1), 64'({on, rgb}), 64'(model_pix(px - 1)));
            if (px <= hi) pixel_x = 10'(px);
        end
        $display("scan x=%0d..%0d new_errors=%0d", lo, hi, errors - bad);
    endtask

    task automatic probe(input int px, input logic [3:0] exp, input string tag);
        @(negedge pclk); pixel_x = 10'(px);
        @(negedge pclk);
        chk(tag, 64'({on, rgb}), 64'(exp));
        $display("probe %s x=%0d on=%0b rgb=%0d", tag, px, on, rgb);
    endtask

    task automatic clear_cars();
        for (int i = 0; i < N; i++) begin
            cx[i] = '0; cy[i] = '0; co[i] = '0; ce[i] = 1'b0;
        end
    endtask

    logic [3*CAR_WIDTH-1:0] pat;

    initial begin
        reset = 1'b1; pixel_x = '0; pixel_y = '0; hblank_start = 1'b0;
        clear_cars();
        for (int a = 0; a < 256; a++) rom_mem[a] = 48'({$urandom, $urandom});
        for (int i = 0; i < N; i++) exp_valid[i] = 1'b0;

        // Reset state.
        repeat (2) @(negedge pclk);
        chk("rst_rgb", 64'(rgb), 64'd0);
        chk("rst_on", 64'(on), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rom_en", 64'(rom_en), 64'd0);
        chk("rst_rom_addr", 64'(rom_addr), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        reset = 1'b0;
        scan(280, 320);  // nothing committed yet: on must stay 0

        // Single car, row 0 fetched for line 100.
        cx[0] = 8'd40; cy[0] = 10'd100; co[0] = 3'd2; ce[0] = 1'b1;
        fetch(99, 1'b0, 0);
        chk("first_addr", 64'(got_addrs.size() > 0 ? got_addrs[0] : -1), 64'd64);
        scan(256 + 30, 256 + 70);

        // Row 32 is past the sprite: no read, blank line.
        fetch(131, 1'b0, 0);
        scan(0, 1023);

        // Overlap priority and transparency.
        for (int c = 0; c < CAR_WIDTH; c++) pat[3*c +: 3] = (c % 2 == 0) ? 3'd0 : 3'(c % 7 + 1);
        rom_mem[1 * 32 + 6] = pat;
        for (int c = 0; c < CAR_WIDTH; c++) pat[3*c +: 3] = 3'd5;
        rom_mem[3 * 32 + 6] = pat;
        clear_cars();
        cx[0] = 8'd100; cy[0] = 10'd200; co[0] = 3'd1; ce[0] = 1'b1;
        cx[1] = 8'd100; cy[1] = 10'd200; co[1] = 3'd3; ce[1] = 1'b1;
        fetch(205, 1'b0, 0);
        probe(256 + 100, 4'b1101, "slot1_through");
        probe(256 + 101, 4'b1010, "slot0_wins");
        scan(256 + 95, 256 + 120);
        chk("no_overrun_yet", 64'(overrun), 64'd0);

        // Four visible slots; a second pulse mid-fetch is ignored.
        clear_cars();
        for (int i = 0; i < N; i++) begin
            cx[i] = 8'(i * 50); cy[i] = 10'd300; co[i] = 3'(i); ce[i] = 1'b1;
        end
        fetch(305, 1'b1, 400);
        chk("busy_14", 64'(busy_cnt), 64'(3 * N + 2));
        chk("overrun_set", 64'(overrun), 64'd1);
        scan(250, 460);

        // target_y wraps to 0 after the last line.
        clear_cars();
        cx[0] = 8'd10; cy[0] = 10'd0; co[0] = 3'd5; ce[0] = 1'b1;
        fetch(LAST_LINE, 1'b0, 0);
        chk("wrap_addr", 64'(got_addrs.size() > 0 ? got_addrs[0] : -1), 64'd160);
        scan(256, 300);

        // Randomized lines.
        for (int it = 0; it < 12; it++) begin
            int py, ty, off, tmp;
            py = $urandom_range(0, LAST_LINE);
            ty = (py == LAST_LINE) ? 0 : py + 1;
            for (int i = 0; i < N; i++) begin
                off = int'($urandom_range(0, 40)) - 4;
                tmp = ty - off;
                if (tmp < 0) tmp = 0;
                cy[i] = 10'(tmp);
                cx[i] = 8'($urandom_range(0, 255));
                co[i] = 3'($urandom_range(0, 7));
                ce[i] = ($urandom_range(0, 3) != 0);
            end
            fetch(py, 1'b0, 0);
            scan(250, 520);
        end

        // Reset while the FSM waits on the ROM aborts the fetch.
        clear_cars();
        cx[0] = 8'd40; cy[0] = 10'd100; co[0] = 3'd2; ce[0] = 1'b1;
        fetch(99, 1'b0, 0);
        scan(256 + 38, 256 + 58);  // line is visible before the abort
        pixel_y = 10'd99;
        @(negedge pclk); hblank_start = 1'b1;
        @(negedge pclk); hblank_start = 1'b0;
        begin
            int cyc;
            cyc = 0;
            while (rom_en !== 1'b1 && cyc < 20) begin
                @(negedge pclk);
                cyc++;
            end
            chk("reached_wait", 64'(rom_en), 64'd1);
        end
        reset = 1'b1;
        @(negedge pclk);
        reset = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_rom_en", 64'(rom_en), 64'd0);
        chk("abort_overrun", 64'(overrun), 64'd0);
        for (int i = 0; i < N; i++) exp_valid[i] = 1'b0;
        repeat (20) @(negedge pclk);
        chk("abort_no_commit", 64'(busy), 64'd0);
        scan(0, 1023);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
